// File: rtl/sig_qpsk_demap_pkg.sv
// Shared constants and types for the SIGNAL-symbol QPSK demapper.
// Data subcarrier window, sample width and the packed FIFO entry.
package sig_qpsk_demap_pkg;

  localparam int SIG_DW         = 12;
  localparam int SIG_DATA_START = 16;
  localparam int SIG_DATA_END   = 495;
  localparam int SIG_NBYTES     = 120;
  localparam int SIG_FIFO_DEPTH = 16;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } sig_byte_t;

  // Sign bits are the hard decisions; zero falls on the positive side.
  function automatic logic [1:0] qpsk_bits(
    input logic re_msb,
    input logic im_msb
  );
    return {im_msb, re_msb};
  endfunction

endpackage

// File: rtl/sig_qpsk_demap_fifo.sv
// Synchronous FIFO with first-word fall-through read port.
// A write while full is only taken when a read frees a slot on the same edge.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wp] <= wr_data;
        wp      <= wp + AW'(1);
      end
      if (do_rd) rp <= rp + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sig_qpsk_demap.sv
// SIGNAL-symbol QPSK demapper: data-subcarrier window, hard decisions,
// byte packing and a byte FIFO towards the SIGNAL-field parser.
module sig_qpsk_demap
  import sig_qpsk_demap_pkg::*;
#(
  parameter int DW         = SIG_DW,
  parameter int DATA_START = SIG_DATA_START,
  parameter int DATA_END   = SIG_DATA_END,
  parameter int FIFO_DEPTH = SIG_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] di_re,
  input  logic signed [DW-1:0] di_im,
  input  logic                 di_vld,
  output logic [7:0]           do_byte,
  output logic                 do_last,
  output logic                 do_vld,
  input  logic                 do_rdy,
  output logic                 ovf,
  output logic                 trunc
);

  localparam logic [9:0] I_START = 10'(DATA_START);
  localparam logic [9:0] I_END   = 10'(DATA_END);
  localparam int         CW      = $clog2(FIFO_DEPTH) + 1;

  logic [9:0]    idx;
  logic [1:0]    slot;
  logic [5:0]    pack;
  logic [1:0]    bits;
  logic          used;
  logic          cut;
  sig_byte_t     wr_q;
  logic          wr_vld;
  sig_byte_t     rd_q;
  logic          full;
  logic          empty;
  logic          rd_en;
  logic [CW-1:0] count;

  assign bits  = qpsk_bits(di_re[DW-1], di_im[DW-1]);
  assign used  = di_vld && idx >= I_START && idx <= I_END;
  // idx still holds the count of samples seen when di_vld drops
  assign cut   = !di_vld && idx > I_START && idx <= I_END;
  assign rd_en = do_rdy && (count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      slot   <= '0;
      pack   <= '0;
      wr_q   <= '0;
      wr_vld <= 1'b0;
      trunc  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      trunc  <= cut;
      wr_vld <= used && slot == 2'd3;
      if (wr_vld && full && !rd_en) ovf <= 1'b1;
      if (!di_vld) begin
        idx  <= '0;
        slot <= '0;
        pack <= '0;
      end else begin
        if (idx != 10'h3ff) idx <= idx + 10'd1;
        if (used) begin
          slot <= slot + 2'd1;
          if (slot == 2'd3) begin
            wr_q.last <= (idx == I_END);
            wr_q.data <= {bits, pack};
            pack      <= '0;
          end else begin
            // shift in from the top so slot 0 lands in bits [1:0]
            pack <= {bits, pack[5:2]};
          end
        end
      end
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_vld),
    .wr_data (wr_q),
    .rd_en   (rd_en),
    .rd_data (rd_q),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign do_vld  = ~empty;
  assign do_byte = rd_q.data;
  assign do_last = rd_q.last;

endmodule

// File: doc/sig_qpsk_demap.md
Name: sig_qpsk_demap

Overview:
- Receiver stage directly downstream of the signal-segment constellation de-scrambler.
- Consumes the de-scrambled frequency-domain samples of the SIGNAL symbol and keeps only the 480 data subcarriers.
- Makes QPSK hard decisions and packs the bits into bytes.
- Buffers the bytes in a small FIFO with a valid/ready handshake to the SIGNAL-field parser.

Parameters:
- DW, 12, signed width of di_re/di_im.
- DATA_START, 16, first data subcarrier index (inclusive).
- DATA_END, 495, last data subcarrier index (inclusive).
- FIFO_DEPTH, 16, output byte FIFO depth (power of 2).

Ports:
- clk  in  1  working clock.
- rst  in  1  reset; asynchronous, active-high.
- di_re  in  DW  de-scrambled real sample (signed).
- di_im  in  DW  de-scrambled imaginary sample (signed).
- di_vld  in  1  sample valid; high continuously for one SIGNAL symbol burst.
- do_byte  out  8  packed decision byte.
- do_last  out  1  marks the final byte of a frame (byte 119).
- do_vld  out  1  do_byte/do_last valid.
- do_rdy  in  1  downstream ready.
- ovf  out  1  sticky overflow flag; cleared only by rst.
- trunc  out  1  one-cycle pulse when a burst ends before DATA_END.

Behaviour:
- Clock and reset: all state updates on posedge clk. Asynchronous active-high reset, applied on posedge rst. At reset: do_byte=0, do_last=0, do_vld=0, ovf=0, trunc=0; FIFO empty; index=0; pack register cleared.
- Index counter (10 bit):
  - Increments on each cycle with di_vld=1. Value is 0 for the first sample of a burst.
  - Saturates at 1023; never wraps.
  - Forced to 0 on any cycle with di_vld=0.
- Data window: a sample is used only when di_vld=1 and DATA_START <= index <= DATA_END. All other samples are ignored.
- Decision per used sample:
  - b0 = di_re[DW-1] (1 if negative).
  - b1 = di_im[DW-1].
  - Zero counts as positive.
- Packing:
  - 2-bit slot counter; 4 subcarriers per byte, LSB first. Byte = {s3.b1,s3.b0, s2.b1,s2.b0, s1.b1,s1.b0, s0.b1,s0.b0}.
  - The sample filling slot 3 completes the byte. That byte is written to the FIFO on the next edge, together with last = (index == DATA_END).
  - 480 subcarriers give exactly 120 bytes per frame.
- Latency: byte-completing sample at edge k; FIFO write at edge k+1; do_vld=1 after edge k+1 if the FIFO was empty (2 cycles).
- FIFO:
  - 9-bit entries {last, byte}; registered output; first-word fall-through at the do_* ports.
  - A read occurs on an edge where do_vld & do_rdy.
  - Write while full with a read on the same edge: write accepted, count unchanged.
  - Write while full with no read: byte dropped, ovf set to 1 (sticky). The pointer and count are not corrupted.
  - Read and write on the same edge while empty: impossible by construction (do_vld=0).
  - do_byte and do_last hold stable while do_vld=1 and do_rdy=0.
- Truncation: if di_vld falls while DATA_START < index <= DATA_END, i.e. the burst ends before the last data subcarrier:
  - The partial pack register is discarded and the slot counter reset.
  - trunc pulses for one cycle on the edge after the falling di_vld.
  - Complete bytes already in the FIFO are still delivered.
  - No byte with last=1 is produced for that burst.
- Back-to-back bursts: the index restarts after a single di_vld=0 cycle. The FIFO continues draining across bursts.
- Reset mid-frame: everything, including FIFO contents and ovf, returns to reset values immediately.

Decomposition:
- Shared package (global define header):
  - SIG_DATA_START=16, SIG_DATA_END=495, SIG_NBYTES=120.
  - Sample width DW=12.
- Natural sub-module: sync_fifo (DEPTH, WIDTH=9, async active-high rst, full/empty/count), reusable elsewhere in the receiver.
- Counter, decision and packing logic stay in the top module.

Test Plan:
- Reset: assert rst mid-burst -> all outputs 0 immediately; after release, do_vld stays 0 with no input.
- Nominal frame, do_rdy=1: 512-sample burst, samples 16..495 with re=-100, im=+100 (b0=1, b1=0) -> 120 bytes of 0x55. Last byte has do_last=1. First do_vld two cycles after sample 19.
- Pattern/zero-boundary: sample i (i>=16) uses re = ((i-16)&1) ? -1 : 0 and im = (((i-16)>>1)&1) ? -1 : 0 -> every byte = 0xE4. Index 15 and 496 carry large negative values and must not affect any byte.
- Backpressure/overflow: do_rdy=0 for the whole frame -> FIFO fills at 16 bytes, ovf=1 on the 17th write. Then release do_rdy -> exactly 16 bytes, equal to frame bytes 0..15, in order.
- Full with simultaneous read: fill the FIFO, then hold do_rdy=1 while writes continue -> no drop, ovf stays 0, byte order preserved.
- Truncation: di_vld low after index 200 (185 data samples = 46 bytes + 1 sample) -> 46 bytes delivered, none with do_last=1, trunc pulses once. The next full burst yields a correct 120-byte frame.
